serial_digit_adder: RTL

Parametrised multi-cycle adder/subtractor and clocked successor of the team's small ripple full adder. Operands are captured on a start handshake. The operation is processed DIGIT bits per clock, least-significant digit first, with the carry held in a register between digits. The result, carry-out and signed-overflow flag are presented with a one-cycle done pulse. It sits in the arithmetic playground as the reusable narrow-datapath adder for wide operands.

---
 rtl/serial_digit_adder_pkg.sv | 25 ++
 rtl/serial_digit_adder_ripple.sv | 32 +++
 rtl/serial_digit_adder.sv | 118 +++++++++++
 3 files changed

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
//   state_t     : controller states (IDLE, RUN)
//   full_add    : 1-bit full adder returning {carry, sum}
//   ndig_of     : number of digit cycles for a WIDTH/DIGIT pair
//   cnt_width   : digit-counter width, $clog2(ndig) with a floor of 1
package serial_digit_adder_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  function automatic int unsigned ndig_of(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/serial_digit_adder_ripple.sv
// Combinational DIGIT-bit ripple adder built from the package full adder.
//   x, y : DIGIT-bit addends
//   ci   : carry in
//   s    : DIGIT-bit sum
//   co   : carry out of the top bit
module digit_ripple_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  // Each stage owns its carry nets so the chain is not one self-referencing vector.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    logic cin_b;
    logic cout_b;
    if (i == 0) begin : g_first
      assign cin_b = ci;
    end else begin : g_next
      assign cin_b = g_bit[i-1].cout_b;
    end
    assign {cout_b, s[i]} = full_add(x[i], y[i], cin_b);
  end

  assign co = g_bit[DIGIT-1].cout_b;

endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder/subtractor: operands captured on start, processed DIGIT
// bits per clock LSB first, result presented with a one-cycle done pulse.
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, sampled only while idle
//   sub      : 0 = a+b+cin, 1 = a-b (cin ignored)
//   a, b, cin: operands, captured with start
//   busy     : operation in progress
//   done     : one-cycle pulse, result valid
//   sum, cout, ovf : last completed result, carry out, signed overflow
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = ndig_of(WIDTH, DIGIT);
  localparam int unsigned CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, acc, acc_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             msba, msbb;
  logic [DIGIT-1:0] ds;
  logic             dco;
  logic             last;

  digit_ripple_adder #(.DIGIT(DIGIT)) u_ripple (
    .x  (a_sr[DIGIT-1:0]),
    .y  (b_sr[DIGIT-1:0]),
    .ci (carry),
    .s  (ds),
    .co (dco)
  );

  assign last = (cnt == LAST);
  assign busy = (state == RUN);

  // New digit enters at the top; after NDIG shifts the accumulator is aligned.
  always_comb begin
    acc_nx = acc >> DIGIT;
    acc_nx[WIDTH-1 -: DIGIT] = ds;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      msba  <= 1'b0;
      msbb  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
            msba  <= a[WIDTH-1];
            msbb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          acc   <= acc_nx;
          carry <= dco;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= acc_nx;
            cout <= dco;
            ovf  <= (msba == msbb) && (acc_nx[WIDTH-1] != msba);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
